// File: rtl/sb_config_pkg.sv
// Shared types and constants for the switch-box configuration loader.
// Holds the loader FSM encoding, default frame field widths and the end-of-stream address.
package sb_config_pkg;

  localparam int CFG_DATA_WIDTH = 32;
  localparam int CFG_ADDR_WIDTH = 8;

  localparam logic [CFG_ADDR_WIDTH-1:0] END_ADDR = {CFG_ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_DONE
  } loader_state_t;

endpackage

// File: rtl/cfg_shift_in.sv
// Serial-in parallel-out shift register, MSB first; new bits enter at bit 0.
// One cycle from shift_en to updated dat; no backpressure of its own.
module cfg_shift_in #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] dat
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (shift_en) begin
      sr_d = {sr_q[WIDTH-2:0], bit_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dat = sr_q;

endmodule

// File: rtl/sb_config_loader.sv
// Assembles serial (addr, data) frames and issues a one-cycle one-hot write strobe per frame.
// Strobe one cycle after the last data bit; cfg_ready drops for that cycle and forever after the end marker.
module sb_config_loader
  import sb_config_pkg::*;
#(
  parameter int DATA_WIDTH  = CFG_DATA_WIDTH,
  parameter int ADDR_WIDTH  = CFG_ADDR_WIDTH,
  parameter int NUM_TARGETS = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_bit,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  output logic [DATA_WIDTH-1:0]  config_data,
  output logic [NUM_TARGETS-1:0] config_en,
  output logic                   load_done,
  output logic                   addr_error,
  output logic [CNT_WIDTH-1:0]   words_loaded
);

  localparam int BC_W = $clog2((DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH);
  localparam logic [BC_W-1:0]       ADDR_LAST = BC_W'(ADDR_WIDTH - 1);
  localparam logic [BC_W-1:0]       DATA_LAST = BC_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] NT        = ADDR_WIDTH'(NUM_TARGETS);
  localparam logic [ADDR_WIDTH-1:0] END_A     = {ADDR_WIDTH{1'b1}};

  loader_state_t          state_q, state_d;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  config_data_q, config_data_d;
  logic [NUM_TARGETS-1:0] config_en_q, config_en_d;
  logic [CNT_WIDTH-1:0]   words_loaded_q, words_loaded_d;
  logic                   addr_error_q, addr_error_d;

  logic [ADDR_WIDTH-1:0]  addr_sr;
  logic [DATA_WIDTH-1:0]  data_sr;
  logic                   addr_shift, data_shift, data_clr;
  logic [ADDR_WIDTH-1:0]  addr_full;
  logic [DATA_WIDTH-1:0]  word_full;

  // Field value including the bit being accepted this cycle.
  assign addr_full = {addr_sr[ADDR_WIDTH-2:0], cfg_bit};
  assign word_full = {data_sr[DATA_WIDTH-2:0], cfg_bit};

  cfg_shift_in #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
    .clk      (clk),
    .reset    (reset),
    .clr      (1'b0),
    .shift_en (addr_shift),
    .bit_in   (cfg_bit),
    .dat      (addr_sr)
  );

  cfg_shift_in #(.WIDTH(DATA_WIDTH)) u_data_sr (
    .clk      (clk),
    .reset    (reset),
    .clr      (data_clr),
    .shift_en (data_shift),
    .bit_in   (cfg_bit),
    .dat      (data_sr)
  );

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    config_data_d  = config_data_q;
    config_en_d    = '0;
    words_loaded_d = words_loaded_q;
    addr_error_d   = addr_error_q;
    cfg_ready      = 1'b0;
    addr_shift     = 1'b0;
    data_shift     = 1'b0;
    data_clr       = 1'b0;
    unique case (state_q)
      S_ADDR: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          addr_shift = 1'b1;
          if (bit_cnt_q == ADDR_LAST) begin
            bit_cnt_d = '0;
            data_clr  = 1'b1;
            state_d   = (addr_full == END_A) ? S_DONE : S_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          data_shift = 1'b1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d     = '0;
            config_data_d = word_full;
            state_d       = S_WRITE;
            // Strobe is registered so it lines up with S_WRITE.
            if (addr_sr < NT) config_en_d = NUM_TARGETS'(1) << addr_sr;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (addr_sr < NT) begin
          if (words_loaded_q != '1) words_loaded_d = words_loaded_q + 1'b1;
        end else begin
          addr_error_d = 1'b1;
        end
        state_d = S_ADDR;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_ADDR;
      bit_cnt_q      <= '0;
      config_data_q  <= '0;
      config_en_q    <= '0;
      words_loaded_q <= '0;
      addr_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      config_data_q  <= config_data_d;
      config_en_q    <= config_en_d;
      words_loaded_q <= words_loaded_d;
      addr_error_q   <= addr_error_d;
    end
  end

  assign config_data  = config_data_q;
  assign config_en    = config_en_q;
  assign words_loaded = words_loaded_q;
  assign addr_error   = addr_error_q;
  assign load_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_sb_config_loader.sv
// Randomised scoreboard bench for sb_config_loader: frame-level reference model feeds an
// expectation queue; an independent monitor checks every write strobe against it.
module tb_sb_config_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_bit;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] config_data;
  logic [15:0] config_en;
  logic        load_done;
  logic        addr_error;
  logic [15:0] words_loaded;

  sb_config_loader dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_bit      (cfg_bit),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .config_data  (config_data),
    .config_en    (config_en),
    .load_done    (load_done),
    .addr_error   (addr_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          exp_words = 0;
  bit          exp_err = 0;
  bit          exp_done = 0;
  logic [31:0] last_data = '0;
  int          cyc = 0;
  int          last_bit_cyc = -10;
  int          gap_pct = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (reset === 1'b0 && config_en !== 16'h0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {48'h0, config_en}, 64'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_en", {48'h0, config_en}, 64'(1) << e.addr);
        check("strobe_data", {32'h0, config_data}, {32'h0, e.data});
        check("strobe_ready_low", {63'h0, cfg_ready}, 64'h0);
        check("strobe_latency", 64'(cyc - last_bit_cyc), 64'd1);
        last_data = e.data;
      end
    end
  end

  // Frame-level reference: what a completed frame should do to the outputs.
  task automatic model_frame(input logic [7:0] a, input logic [31:0] d);
    if (a == 8'hFF) begin
      exp_done = 1;
    end else if (a < 8'd16) begin
      exp_q.push_back('{addr: a, data: d});
      if (exp_words < 65535) exp_words++;
    end else begin
      exp_err = 1;
    end
  endtask

  task automatic send_bit(input logic b);
    int waited = 0;
    if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_bit   = 1'($urandom);
    end
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    while (cfg_ready !== 1'b1) begin
      waited++;
      if (waited > 100) begin
        check("ready_timeout", {63'h0, cfg_ready}, 64'h1);
        break;
      end
      @(negedge clk);
    end
    last_bit_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cfg_valid = 1'b0;
    end
  endtask

  // stall_at: number of bits accepted before a stall of stall_len cycles.
  task automatic send_frame(input logic [7:0] a, input logic [31:0] d,
                            input int stall_at, input int stall_len);
    logic [39:0] v;
    int nbits;
    v = {a, d};
    nbits = (a == 8'hFF) ? 8 : 40;
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_at) begin
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (stall_len - 1) @(negedge clk);
        check("stall_data_hold", {32'h0, config_data}, {32'h0, last_data});
        check("stall_ready", {63'h0, cfg_ready}, 64'h1);
      end
      if (i == nbits - 1) model_frame(a, d);
      send_bit(v[39-i]);
    end
  endtask

  task automatic settle();
    idle(2);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_words"}, {48'h0, words_loaded}, 64'(exp_words));
    check({tag, "_err"}, {63'h0, addr_error}, {63'h0, exp_err});
    check({tag, "_done"}, {63'h0, load_done}, {63'h0, exp_done});
    check({tag, "_ready"}, {63'h0, cfg_ready}, {63'h0, !exp_done});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    cfg_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_words = 0;
    exp_err   = 0;
    exp_done  = 0;
    last_data = '0;
    check("rst_data", {32'h0, config_data}, 64'h0);
    check("rst_en", {48'h0, config_en}, 64'h0);
    check_status("rst");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // Basic frame, valid held high.
    send_frame(8'h03, 32'hDEADBEEF, -1, 0);
    settle();
    check_status("basic");

    // Same frame, 5-cycle stall after 20 accepted bits.
    send_frame(8'h03, 32'hDEADBEEF, 20, 5);
    settle();
    check_status("stall");

    // Out-of-range target, then a normal write.
    send_frame(8'h20, 32'h1, -1, 0);
    settle();
    check_status("oob");
    send_frame(8'h00, 32'h12345678, -1, 0);
    settle();
    check_status("after_oob");

    // Random frames with random valid gaps.
    gap_pct = 30;
    for (int f = 0; f < 25; f++) begin
      a = ($urandom_range(99) < 75) ? 8'($urandom_range(15)) : 8'($urandom_range(16, 254));
      send_frame(a, $urandom, -1, 0);
      settle();
      check_status("rand");
    end
    gap_pct = 0;

    // Reset after 12 data bits discards the partial frame.
    do_reset();
    for (int i = 0; i < 20; i++) send_bit(i < 8 ? (i == 7) : 1'($urandom));
    do_reset();
    send_frame(8'h01, 32'hA5A5A5A5, 30, 3);
    settle();
    check_status("abort");

    // Saturation of the write counter.
    @(negedge clk);
    force dut.words_loaded_q = 16'hFFFF;
    @(negedge clk);
    release dut.words_loaded_q;
    exp_words = 65535;
    @(negedge clk);
    check_status("sat_pre");
    send_frame(8'h05, 32'h0BADF00D, -1, 0);
    settle();
    check_status("sat");

    // Back-to-back frames, then end marker; later bits ignored.
    do_reset();
    send_frame(8'h00, $urandom, -1, 0);
    send_frame(8'h0F, $urandom, -1, 0);
    send_frame(8'h07, $urandom, -1, 0);
    send_frame(8'hFF, 32'h0, -1, 0);
    settle();
    check_status("end");
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_bit   = 1'($urandom);
    end
    idle(2);
    check_status("end_hold");
    check("exp_queue_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
